// File: rtl/spr_line_sched.sv
// Purpose : per-scanline sprite evaluation; scans one attribute bank and queues a render
//           descriptor for each sprite covering the target line.
// Latency : a miss takes 2 cycles (RY,CY) and a hit takes 5 cycles (RY,CY,CX,CA,CC). A push
//           into an empty queue shows on ENT_VLD the following cycle.
// Backpressure: when the descriptor queue is full, the scan parks in HOLD with SAAD frozen.
//           A pop frees a slot for the next cycle, not for the same cycle.
// Ports   : VCLKx8/RESET clock and async reset; LSTART/SPVP/BANK start a line scan;
//           SAAD/SATD sprite RAM read port (1-cycle latency); ENT_* descriptor valid/ready
//           output; HITS/OVF/LDONE per-line status.
module spr_line_sched #(
   parameter int SPRITES  = 48,
   parameter int FIFO_DEP = 8,
   parameter int MAX_HITS = 16
) (
   input  logic        VCLKx8,
   input  logic        RESET,
   input  logic        LSTART,
   input  logic [8:0]  SPVP,
   input  logic        BANK,
   output logic [11:0] SAAD,
   input  logic [7:0]  SATD,
   output logic        ENT_VLD,
   input  logic        ENT_RDY,
   output logic [8:0]  ENT_CODE,
   output logic [3:0]  ENT_COLOR,
   output logic        ENT_FX,
   output logic        ENT_FY,
   output logic [8:0]  ENT_X,
   output logic [3:0]  ENT_LY,
   output logic [4:0]  HITS,
   output logic        OVF,
   output logic        LDONE
);

   typedef struct packed {
      logic [8:0] code;
      logic [3:0] color;
      logic       fx;
      logic       fy;
      logic [8:0] x;
      logic [3:0] ly;
   } ent_t;

   localparam int AW = $clog2(FIFO_DEP);
   localparam logic [6:0] SPR_CNT = 7'(SPRITES);
   localparam logic [4:0] HIT_MAX = 5'(MAX_HITS);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RY   = 3'd1;
   localparam logic [2:0] S_CY   = 3'd2;
   localparam logic [2:0] S_CX   = 3'd3;
   localparam logic [2:0] S_CA   = 3'd4;
   localparam logic [2:0] S_CC   = 3'd5;
   localparam logic [2:0] S_HOLD = 3'd6;
   localparam logic [2:0] S_DONE = 3'd7;

   logic [2:0]  state;
   logic [8:0]  spvp_q;
   logic        bank_q;
   logic [5:0]  sano;
   logic [3:0]  ht_q;
   logic [7:0]  x_q;
   logic [7:0]  attr_q;
   ent_t        hold_q;
   logic [4:0]  hits_q;
   logic        ovf_q;
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   ent_t        mem [FIFO_DEP];

   logic [8:0]  ht;
   logic        y_hit;
   ent_t        cc_ent;
   ent_t        push_ent;
   ent_t        head;
   logic        fifo_full;
   logic        fifo_empty;
   logic        push;
   logic        pop;
   logic [6:0]  sano_inc;
   logic [4:0]  hits_inc;
   logic        push_done;
   logic [1:0]  saof;

   // Line offset from sprite top: a sprite covers the line when ht is in -16..-1.
   assign ht    = {1'b0, SATD} - spvp_q;
   assign y_hit = (SATD != 8'h00) && (ht[8:4] == 5'b11111);

   always_comb begin
      cc_ent       = '0;
      cc_ent.code  = {attr_q[6], SATD};
      cc_ent.color = attr_q[3:0];
      cc_ent.fx    = attr_q[4];
      cc_ent.fy    = attr_q[5];
      cc_ent.x     = {1'b0, x_q} - {attr_q[7], 8'h00};
      cc_ent.ly    = ht_q ^ {4{~attr_q[5]}};
   end

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign push_ent   = (state == S_CC) ? cc_ent : hold_q;
   // Fullness comes from registered pointers, so a same-cycle pop never admits a push.
   assign push       = !LSTART && ((state == S_CC) || (state == S_HOLD)) && !fifo_full;
   assign pop        = !LSTART && !fifo_empty && ENT_RDY;
   assign sano_inc   = {1'b0, sano} + 7'd1;
   assign hits_inc   = hits_q + 5'd1;
   assign push_done  = (sano_inc == SPR_CNT) || (hits_inc == HIT_MAX);

   // The CY address is issued speculatively. On a miss the next sprite's RY overrides it,
   // so the X byte read that results is simply unused.
   always_comb begin
      saof = 2'd0;
      SAAD = 12'h000;
      case (state)
         S_RY:                saof = 2'd3;
         S_CY:                saof = 2'd2;
         S_CX:                saof = 2'd1;
         default:             saof = 2'd0;
      endcase
      if (state != S_IDLE && state != S_DONE)
         SAAD = {3'b000, bank_q, sano, saof};
   end

   assign head      = mem[rd_ptr[AW-1:0]];
   assign ENT_VLD   = !fifo_empty;
   assign ENT_CODE  = ENT_VLD ? head.code  : 9'h000;
   assign ENT_COLOR = ENT_VLD ? head.color : 4'h0;
   assign ENT_FX    = ENT_VLD ? head.fx    : 1'b0;
   assign ENT_FY    = ENT_VLD ? head.fy    : 1'b0;
   assign ENT_X     = ENT_VLD ? head.x     : 9'h000;
   assign ENT_LY    = ENT_VLD ? head.ly    : 4'h0;
   assign HITS      = hits_q;
   assign OVF       = ovf_q;
   assign LDONE     = ((state == S_IDLE) || (state == S_DONE)) && fifo_empty;

   always_ff @(posedge VCLKx8) begin
      if (push)
         mem[wr_ptr[AW-1:0]] <= push_ent;
   end

   always_ff @(posedge VCLKx8 or posedge RESET) begin
      if (RESET) begin
         state  <= S_IDLE;
         spvp_q <= '0;
         bank_q <= 1'b0;
         sano   <= '0;
         ht_q   <= '0;
         x_q    <= '0;
         attr_q <= '0;
         hold_q <= '0;
         hits_q <= '0;
         ovf_q  <= 1'b0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (LSTART) begin
         // A line start wins over everything: the old line's work is discarded.
         state  <= S_RY;
         spvp_q <= SPVP;
         bank_q <= BANK;
         sano   <= '0;
         hits_q <= '0;
         ovf_q  <= 1'b0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
            hits_q <= hits_inc;
            sano   <= sano_inc[5:0];
            if (hits_inc == HIT_MAX)
               ovf_q <= 1'b1;
         end
         case (state)
            S_RY: state <= S_CY;
            S_CY: begin
               if (y_hit) begin
                  ht_q  <= ht[3:0];
                  state <= S_CX;
               end else begin
                  sano  <= sano_inc[5:0];
                  state <= (sano_inc == SPR_CNT) ? S_DONE : S_RY;
               end
            end
            S_CX: begin
               x_q   <= SATD;
               state <= S_CA;
            end
            S_CA: begin
               attr_q <= SATD;
               state  <= S_CC;
            end
            S_CC, S_HOLD: begin
               if (push)
                  state <= push_done ? S_DONE : S_RY;
               else begin
                  if (state == S_CC)
                     hold_q <= cc_ent;
                  state <= S_HOLD;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_spr_line_sched.sv
// Purpose : directed self-checking bench for spr_line_sched with a 1-cycle-latency sprite RAM model.
// Latency : cycle n is sampled 1 time unit after the nth rising edge following the LSTART cycle.
// Backpressure: ENT_RDY is driven directly by each scenario.
module tb_spr_line_sched;

   logic        VCLKx8 = 1'b0;
   logic        RESET  = 1'b1;
   logic        LSTART = 1'b0;
   logic [8:0]  SPVP   = 9'h000;
   logic        BANK   = 1'b0;
   logic [11:0] SAAD;
   logic [7:0]  SATD   = 8'h00;
   logic        ENT_VLD;
   logic        ENT_RDY = 1'b0;
   logic [8:0]  ENT_CODE;
   logic [3:0]  ENT_COLOR;
   logic        ENT_FX;
   logic        ENT_FY;
   logic [8:0]  ENT_X;
   logic [3:0]  ENT_LY;
   logic [4:0]  HITS;
   logic        OVF;
   logic        LDONE;

   logic [7:0]  ram [0:4095];
   logic [8:0]  got_codes [$];
   int          n_checks = 0;
   int          n_errors = 0;

   spr_line_sched dut (
      .VCLKx8(VCLKx8), .RESET(RESET), .LSTART(LSTART), .SPVP(SPVP), .BANK(BANK),
      .SAAD(SAAD), .SATD(SATD), .ENT_VLD(ENT_VLD), .ENT_RDY(ENT_RDY),
      .ENT_CODE(ENT_CODE), .ENT_COLOR(ENT_COLOR), .ENT_FX(ENT_FX), .ENT_FY(ENT_FY),
      .ENT_X(ENT_X), .ENT_LY(ENT_LY), .HITS(HITS), .OVF(OVF), .LDONE(LDONE)
   );

   always #5 VCLKx8 = ~VCLKx8;

   always @(posedge VCLKx8) SATD <= ram[SAAD];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge VCLKx8);
      #1;
   endtask

   task automatic pulse_lstart();
      LSTART = 1'b1;
      tick();
      LSTART = 1'b0;
   endtask

   task automatic clear_ram();
      for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
   endtask

   task automatic set_sprite(input logic bnk, input int idx, input logic [7:0] y,
                             input logic [7:0] x, input logic [7:0] attr, input logic [7:0] code);
      logic [11:0] base;
      base = {3'b000, bnk, 6'(idx), 2'b00};
      ram[base + 12'd3] = y;
      ram[base + 12'd2] = x;
      ram[base + 12'd1] = attr;
      ram[base]         = code;
   endtask

   // Accepts entries until the line completes; an expired budget appears as a failed LDONE check.
   task automatic drain(input int budget, input string tag);
      int n;
      n = 0;
      got_codes.delete();
      while (!LDONE && n < budget) begin
         if (ENT_VLD && ENT_RDY) got_codes.push_back(ENT_CODE);
         tick();
         n++;
      end
      check({tag, "_ldone"}, 32'(LDONE), 32'd1);
   endtask

   task automatic setup_hits(input int n);
      clear_ram();
      for (int i = 0; i < n; i++)
         set_sprite(1'b0, i, 8'h40, 8'(i), 8'h00, 8'(i + 1));
      SPVP = 9'h045;
      BANK = 1'b0;
   endtask

   initial begin
      clear_ram();
      #12;
      check("rst_saad", 32'(SAAD), 32'h0);
      check("rst_vld", 32'(ENT_VLD), 32'd0);
      check("rst_code", 32'(ENT_CODE), 32'd0);
      check("rst_hits", 32'(HITS), 32'd0);
      check("rst_ovf", 32'(OVF), 32'd0);
      check("rst_ldone", 32'(LDONE), 32'd1);
      RESET = 1'b0;
      tick();

      // 1) all Y=0: a pure miss walk over sprites 0..47
      begin
         bit seen_vld;
         seen_vld = 1'b0;
         SPVP = 9'h010;
         pulse_lstart();
         for (int c = 1; c <= 96; c++) begin
            if (c % 2 == 1)
               check($sformatf("t1_saad_%0d", c), 32'(SAAD), 32'({3'b000, 1'b0, 6'((c - 1) / 2), 2'd3}));
            if (ENT_VLD) seen_vld = 1'b1;
            if (c == 96) check("t1_ldone96", 32'(LDONE), 32'd0);
            tick();
         end
         check("t1_ldone97", 32'(LDONE), 32'd1);
         check("t1_never_vld", 32'(seen_vld), 32'd0);
      end

      // 2) a single hit on sprite 5, with SPVP changed after it has been latched
      clear_ram();
      set_sprite(1'b0, 5, 8'h40, 8'h10, 8'h93, 8'h21);
      SPVP = 9'h045;
      ENT_RDY = 1'b0;
      pulse_lstart();
      SPVP = 9'h000;
      repeat (14) tick();
      check("t2_vld15", 32'(ENT_VLD), 32'd0);
      tick();
      check("t2_vld16", 32'(ENT_VLD), 32'd1);
      check("t2_code", 32'(ENT_CODE), 32'h021);
      check("t2_color", 32'(ENT_COLOR), 32'h3);
      check("t2_fx", 32'(ENT_FX), 32'd1);
      check("t2_fy", 32'(ENT_FY), 32'd0);
      check("t2_x", 32'(ENT_X), 32'h110);
      check("t2_ly", 32'(ENT_LY), 32'h4);
      check("t2_hits", 32'(HITS), 32'd1);
      ENT_RDY = 1'b1;
      tick();
      check("t2_popped", 32'(ENT_VLD), 32'd0);
      drain(300, "t2");

      // 3) 10 hits against a stalled renderer: 8 queued, then HOLD, then release
      setup_hits(10);
      ENT_RDY = 1'b0;
      pulse_lstart();
      repeat (60) tick();
      check("t3_vld", 32'(ENT_VLD), 32'd1);
      check("t3_hits", 32'(HITS), 32'd8);
      check("t3_saad_hold", 32'(SAAD), 32'h020);
      check("t3_ldone", 32'(LDONE), 32'd0);
      check("t3_head", 32'(ENT_CODE), 32'd1);
      repeat (5) tick();
      check("t3_saad_frozen", 32'(SAAD), 32'h020);
      check("t3_head_stable", 32'(ENT_CODE), 32'd1);
      ENT_RDY = 1'b1;
      drain(1000, "t3");
      check("t3_count", 32'(got_codes.size()), 32'd10);
      for (int i = 0; i < got_codes.size() && i < 10; i++)
         check($sformatf("t3_order_%0d", i), 32'(got_codes[i]), 32'(i + 1));
      check("t3_hits_end", 32'(HITS), 32'd10);

      // 4) 20 candidate hits: the scan stops at 16 and flags overflow
      setup_hits(20);
      ENT_RDY = 1'b1;
      pulse_lstart();
      drain(1000, "t4");
      check("t4_count", 32'(got_codes.size()), 32'd16);
      for (int i = 0; i < got_codes.size() && i < 16; i++)
         check($sformatf("t4_order_%0d", i), 32'(got_codes[i]), 32'(i + 1));
      check("t4_ovf", 32'(OVF), 32'd1);
      check("t4_hits", 32'(HITS), 32'd16);
      pulse_lstart();
      check("t4_ovf_clr", 32'(OVF), 32'd0);
      check("t4_hits_clr", 32'(HITS), 32'd0);
      drain(300, "t4b");

      // 5) abort a scan with 3 entries queued and switch to bank 1
      setup_hits(3);
      ENT_RDY = 1'b0;
      pulse_lstart();
      repeat (17) tick();
      check("t5_vld_before", 32'(ENT_VLD), 32'd1);
      check("t5_hits_before", 32'(HITS), 32'd3);
      BANK = 1'b1;
      SPVP = 9'h1FF;
      pulse_lstart();
      BANK = 1'b0;
      check("t5_vld_flushed", 32'(ENT_VLD), 32'd0);
      check("t5_saad_restart", 32'(SAAD), 32'h103);
      check("t5_hits_clr", 32'(HITS), 32'd0);
      repeat (2) tick();
      check("t5_bank_latched", 32'(SAAD), 32'h107);
      drain(300, "t5");

      // 6) asynchronous reset while parked in HOLD
      setup_hits(10);
      ENT_RDY = 1'b0;
      pulse_lstart();
      repeat (60) tick();
      check("t6_saad_hold", 32'(SAAD), 32'h020);
      RESET = 1'b1;
      #1;
      check("t6_saad", 32'(SAAD), 32'h0);
      check("t6_vld", 32'(ENT_VLD), 32'd0);
      check("t6_code", 32'(ENT_CODE), 32'd0);
      check("t6_hits", 32'(HITS), 32'd0);
      check("t6_ovf", 32'(OVF), 32'd0);
      check("t6_ldone", 32'(LDONE), 32'd1);
      tick();
      RESET = 1'b0;
      tick();
      check("t6_idle_ldone", 32'(LDONE), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
